// File: rtl/ysyx_24080014_ifu.sv
// rtl/ysyx_24080014_ifu.sv - instruction fetch unit: one AR/R read per PC, valid/ready delivery to decode
module ysyx_24080014_ifu #(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int TIMEOUT = 255
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] pc,
    input  logic              commit_valid,
    output logic [ADDR_W-1:0] araddr,
    output logic              arvalid,
    input  logic              arready,
    input  logic [DATA_W-1:0] rdata,
    input  logic [1:0]        rresp,
    input  logic              rvalid,
    output logic              rready,
    output logic [DATA_W-1:0] inst,
    output logic [ADDR_W-1:0] inst_pc,
    output logic              inst_valid,
    input  logic              inst_ready,
    output logic              fetch_err
);

    typedef enum logic [2:0] {IDLE, SYNC, AR, R, OUT} state_t;

    localparam logic [7:0]        CNT_LAST = 8'(TIMEOUT - 1);
    localparam logic [DATA_W-1:0] NOP      = DATA_W'(32'h00000013);

    state_t            state;
    state_t            state_next;
    logic [ADDR_W-1:0] addr_q;
    logic              addr_lat;
    logic [7:0]        cnt;
    logic              timed_out;
    logic              illegal_event;

    assign timed_out = (state == R) && !rvalid && (cnt == CNT_LAST);

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= AR;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE: if (commit_valid) state_next = SYNC;
            SYNC: state_next = AR;
            AR:   if (arready) state_next = R;
            R:    if (rvalid || timed_out) state_next = OUT;
            OUT:  if (inst_ready) state_next = commit_valid ? SYNC : IDLE;
            default: state_next = AR;
        endcase
    end

    // Until the first AR edge latches it, the address is taken straight from pc,
    // so the very first cycle after reset already presents the live PC.
    always_comb begin
        arvalid    = (state == AR);
        rready     = (state == R);
        inst_valid = (state == OUT);
        araddr     = (state == AR && !addr_lat) ? pc : addr_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            addr_q    <= '0;
            addr_lat  <= 1'b0;
            cnt       <= '0;
            inst      <= '0;
            inst_pc   <= '0;
            fetch_err <= 1'b0;
        end else begin
            case (state)
                SYNC: addr_lat <= 1'b0;
                AR: begin
                    if (!addr_lat) begin
                        addr_q   <= pc;
                        addr_lat <= 1'b1;
                    end
                    if (arready) cnt <= '0;
                end
                R: begin
                    if (rvalid) begin
                        inst    <= rdata;
                        inst_pc <= addr_q;
                        if (rresp != 2'b00) fetch_err <= 1'b1;
                    end else begin
                        cnt <= cnt + 8'd1;
                        if (timed_out) begin
                            inst      <= NOP;
                            inst_pc   <= addr_q;
                            fetch_err <= 1'b1;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    // A commit pulse is only meaningful while waiting in IDLE or handing off in OUT.
    assign illegal_event = commit_valid && (state != IDLE) && (state != OUT);

    always_ff @(posedge clk) begin
        if (!rst) begin
            assert (!illegal_event);
        end
    end

endmodule
